// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: two-requester write-port arbiter for a register bank.
// A request wins in IDLE and gets a one-cycle gnt. Its address and data are
// captured, and the next cycle (WR0/WR1) drives a one-hot wr_en with the
// captured data. Contention policy is chosen at build time:
//   REGFILE_ARB_RR_EN defined   -> round-robin pointer
//   REGFILE_ARB_RR_EN undefined -> fixed priority, requester 0 wins
module regfile_wr_arbiter #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic                req1,
  input  logic [AW-1:0]       addr0,
  input  logic [AW-1:0]       addr1,
  input  logic [DATA_W-1:0]   data0,
  input  logic [DATA_W-1:0]   data1,
  output logic                gnt0,
  output logic                gnt1,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR0  = 2'd1,
    WR1  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                armed;
  logic                pick1;
  logic                grant_any;
  logic [AW-1:0]       cap_addr;
  logic [DATA_W-1:0]   cap_data;
  logic [NUM_REGS-1:0] dec;

`ifdef REGFILE_ARB_RR_EN
  // prio=1 means requester 1 wins when both request
  logic prio;

  // Pointer moves to the non-winner after every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         prio <= 1'b0;
    else if (grant_any) prio <= ~pick1;
  end

  assign pick1 = req1 & (~req0 | prio);
`else
  assign pick1 = req1 & ~req0;
`endif

  // Grants are held off until the first rising edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the winner's address and data on its grant cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= '0;
      cap_data <= '0;
    end else if (grant_any) begin
      cap_addr <= pick1 ? addr1 : addr0;
      cap_data <= pick1 ? data1 : data0;
    end
  end

  // Address decode; out-of-range addresses match no bit and drop the write
  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      dec[i] = (cap_addr == AW'(i));
    end
  end

  // Next-state, grant and write-enable logic
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    grant_any = 1'b0;
    wr_en     = '0;
    case (state)
      IDLE: begin
        if (armed && (req0 || req1)) begin
          grant_any = 1'b1;
          gnt0      = ~pick1;
          gnt1      = pick1;
          state_nxt = pick1 ? WR1 : WR0;
        end
      end
      WR0, WR1: begin
        wr_en     = dec;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign wr_data = cap_data;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: scoreboard bench for regfile_wr_arbiter.
// The stimulus process runs a transaction-level model of the arbiter and
// queues expected grants and writes; a monitor pops and compares them when
// the DUT shows gnt or busy. Honours REGFILE_ARB_RR_EN for the policy.
module tb_regfile_wr_arbiter;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          gnt0, gnt1, busy;
  logic [NR-1:0] wr_en;
  logic [DW-1:0] wr_data;

  regfile_wr_arbiter #(.DATA_W(DW), .NUM_REGS(NR), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .wr_en(wr_en), .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct { int due; int who; } gexp_t;
  typedef struct { int due; logic [NR-1:0] en; logic [DW-1:0] d; } wexp_t;
  gexp_t gq[$];
  wexp_t wq[$];

  // Transaction-level model state
  int            m_ptr  = 0;
  bit            m_pend = 0;
  bit            act[2];
  logic [AW-1:0] ad[2];
  logic [DW-1:0] dt[2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [NR-1:0] onehot(input logic [AW-1:0] a);
    logic [NR-1:0] r;
    r = '0;
    if (int'(a) < NR) r[a] = 1'b1;
    return r;
  endfunction

  task automatic new_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (!act[i]) begin
      act[i] = 1'b1;
      ad[i]  = a;
      dt[i]  = d;
    end
  endtask

  // One clock cycle: drive requester state, then predict this cycle's outcome
  task automatic step(input bit arb);
    int    w;
    gexp_t ge;
    wexp_t we;
    @(posedge clk);
    #1;
    req0 = act[0]; addr0 = ad[0]; data0 = dt[0];
    req1 = act[1]; addr1 = ad[1]; data1 = dt[1];
    if (m_pend) begin
      m_pend = 0;
    end else if (arb && (act[0] || act[1])) begin
      if (act[0] && act[1]) w = m_ptr;
      else                  w = act[1] ? 1 : 0;
      ge.due = cyc;     ge.who = w;
      we.due = cyc + 1; we.en = onehot(ad[w]); we.d = dt[w];
      gq.push_back(ge);
      wq.push_back(we);
`ifdef REGFILE_ARB_RR_EN
      m_ptr = 1 - w;
`endif
      act[w] = 1'b0;
      m_pend = 1;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && (m_pend || act[0] || act[1]); k++) step(1);
    step(1);
  endtask

  // Monitor: compares DUT activity against queued expectations
  logic [DW-1:0] hold = '0;
  initial begin
    gexp_t g;
    wexp_t w;
    forever begin
      @(negedge clk);
      if (gnt0 && gnt1) fail("gnt_exclusive");
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) fail("unexpected_gnt");
        else begin
          g = gq.pop_front();
          check("gnt_who", 64'({gnt1, gnt0}), 64'(g.who == 1 ? 2 : 1));
          check("gnt_cycle", 64'(cyc), 64'(g.due));
        end
      end
      if (busy) begin
        if (wq.size() == 0) fail("unexpected_write");
        else begin
          w = wq.pop_front();
          check("wr_en", 64'(wr_en), 64'(w.en));
          check("wr_data", 64'(wr_data), 64'(w.d));
          check("wr_cycle", 64'(cyc), 64'(w.due));
          hold = w.d;
        end
      end else begin
        check("idle_wr_en", 64'(wr_en), 64'(0));
        if (!rst_n) hold = '0;
        check("wr_data_hold", 64'(wr_data), 64'(hold));
      end
      while (gq.size() > 0 && gq[0].due <= cyc) begin
        fail("missing_gnt");
        void'(gq.pop_front());
      end
      while (wq.size() > 0 && wq[0].due <= cyc) begin
        fail("missing_write");
        void'(wq.pop_front());
      end
    end
  end

  initial begin
    act[0] = 1'b1; ad[0] = 5'd2; dt[0] = 32'h1111_0000;
    act[1] = 1'b1; ad[1] = 5'd4; dt[1] = 32'h2222_0000;
    req0 = 1'b1; req1 = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt0", 64'(gnt0), 64'(0));
    check("rst_gnt1", 64'(gnt1), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    step(0);
    step(0);
    rst_n = 1'b1;
    drain();

    // Single request
    new_req(0, 5'd3, 32'hDEADBEEF);
    drain();

    // Contention, distinct addresses
    new_req(0, 5'd1, 32'hA000_0001);
    new_req(1, 5'd2, 32'hB000_0002);
    drain();

    // req0 kept busy across several writes while req1 waits
    new_req(1, 5'd9, 32'hC000_0009);
    for (int k = 0; k < 8; k++) begin
      if (!act[0]) new_req(0, AW'(k), $urandom);
      step(1);
    end
    act[0] = 1'b0;
    drain();

    // Same address from both requesters
    new_req(0, 5'd7, 32'h1);
    new_req(1, 5'd7, 32'h2);
    drain();

    // Out-of-range address
    new_req(0, 5'd20, 32'h5555_AAAA);
    drain();

    // Reset during a WR1 write
    new_req(1, 5'd5, 32'h0BAD_F00D);
    step(1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    void'(wq.pop_back());
    m_pend = 0;
    m_ptr  = 0;
    #1;
    check("midrst_wr_en", 64'(wr_en), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_wr_data", 64'(wr_data), 64'(0));
    step(0);
    step(0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1);

    // Randomized traffic with withdrawals
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          if ($urandom_range(0, 2) == 0) new_req(i, AW'($urandom_range(0, 31)), $urandom);
        end else if ($urandom_range(0, 9) == 0) begin
          act[i] = 1'b0;
        end
      end
      step(1);
    end
    act[0] = 1'b0;
    act[1] = 1'b0;
    drain();
    step(1);

    check("gnt_queue_empty", 64'(gq.size()), 64'(0));
    check("wr_queue_empty", 64'(wq.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of write data and of each register in the bank.
REQ-002 SHALL have parameter NUM_REGS, default 32: number of registers in the bank; width of wr_en.
REQ-003 SHALL have parameter AW, default 5: register address width, equal to log2(NUM_REGS).
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports req0 and req1, input, 1 each: write request from requester 0 (ALU writeback) and requester 1 (load writeback).
REQ-007 SHALL have ports addr0 and addr1, input, AW each: target register index for each requester.
REQ-008 SHALL have ports data0 and data1, input, DATA_W each: write data for each requester.
REQ-009 SHALL have ports gnt0 and gnt1, output, 1 each: one-cycle acceptance pulse to each requester.
REQ-010 SHALL have port wr_en, output, NUM_REGS: one-hot per-register enable driven to the register bank.
REQ-011 SHALL have port wr_data, output, DATA_W: data driven to all registers in the bank.
REQ-012 SHALL have port busy, output, 1: high while a write is in flight (state not IDLE).

Function
REQ-013 SHALL implement FSM states IDLE, WR0 and WR1, with the state register updated on the clk rising edge.
REQ-014 SHALL, in IDLE, select the winner combinationally: a single request wins; if both requests are high, the requester indicated by the priority pointer wins.
REQ-015 SHALL pulse gnt of the winner high for exactly one cycle (the IDLE cycle in which it is selected), capture its addr and data, and move to WR0 or WR1.
REQ-016 SHALL, in WR0 or WR1, drive wr_en with the single bit at the captured address set and wr_data with the captured data, for exactly one cycle, then return to IDLE.
REQ-017 SHALL accept a requester's data on the cycle its gnt is high; requester keeps req, addr and data stable until gnt; requester may deassert req without penalty before gnt.
REQ-018 SHALL drive gnt0 and gnt1 low in WR0 and WR1; requests arriving then wait for IDLE. Maximum throughput is one write per 2 cycles.
REQ-019 SHALL keep wr_en all-zero in IDLE; wr_data holds its last value.
REQ-020 SHALL give a grant-to-write latency of 1 cycle: gnt in cycle N, wr_en in cycle N+1, bank updated at end of N+1.
REQ-021 SHALL never assert gnt0 and gnt1 in the same cycle, and SHALL never drive more than one wr_en bit high.
REQ-022 SHALL drive all wr_en bits low when the captured address is >= NUM_REGS; gnt is still issued and the write is silently dropped.
REQ-023 SHALL, when both requests target the same address, serialize them in arbitration order, so the last granted write is the one retained.

Reset
REQ-024 SHALL, on rst_n low regardless of clk, immediately force state=IDLE, gnt0=gnt1=0, wr_en=0, wr_data=0, busy=0, and priority pointer=requester 0.
REQ-025 SHALL abort any in-flight write if reset is asserted mid-operation: no wr_en pulse, and the aborted requester is not re-granted automatically.
REQ-026 SHALL allow its first grant no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL use the macro REGFILE_ARB_RR_EN to select the arbitration policy.
REQ-028 SHALL, when REGFILE_ARB_RR_EN is defined, use a round-robin pointer that toggles to the non-winner after every grant on contention, and after any single grant to the non-winner.
REQ-029 SHALL, when REGFILE_ARB_RR_EN is not defined, use fixed priority with requester 0 always winning on contention and no pointer register implemented.

Verification
REQ-030 SHALL cover single request: req0=1, addr0=3, data0=0xDEADBEEF -> gnt0 pulses cycle N; wr_en=0x00000008 and wr_data=0xDEADBEEF in cycle N+1; busy=1 in N+1 only.
REQ-031 SHALL cover contention with REGFILE_ARB_RR_EN defined: req0 and req1 held high, addr0=1, addr1=2 -> gnt0 in cycle N, gnt1 in cycle N+2; wr_en=0x2 in N+1 and 0x4 in N+3.
REQ-032 SHALL cover contention with REGFILE_ARB_RR_EN undefined: req0 held high across 4 writes while req1 is high -> gnt1 is never asserted while req0 remains high.
REQ-033 SHALL cover same-address writes: addr0=addr1=7, data0=0x1, data1=0x2, both requests high -> two wr_en=0x80 pulses, with the later pulse carrying the data of the second grant.
REQ-034 SHALL cover reset mid-write: rst_n driven low during WR1 -> wr_en=0 and busy=0 immediately, and there is no wr_en pulse after reset release until a new grant.
REQ-035 SHALL cover out-of-range address with NUM_REGS=16, AW=5: addr0=20 -> gnt0 pulses, and wr_en stays 0.
